// File: rtl/sorted_frame_collector.sv
// Reassembles the sorter's serial word stream into N-word frames, flags order/framing
// problems and queues up to two frames. Define FRAME_SUM_EN to add the frame_sum output.
module sorted_frame_collector #(
    parameter int unsigned DW = 8,
    parameter int unsigned N  = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [DW-1:0]           sort_in,
    input  logic                    sort_valid,
    input  logic                    sort_first,
    output logic [N*DW-1:0]         frame_data,
    output logic                    frame_sorted,
    output logic                    frame_valid,
    input  logic                    frame_ready,
    output logic                    frame_err,
    output logic                    overflow,
`ifdef FRAME_SUM_EN
    output logic [DW+$clog2(N)-1:0] frame_sum,
`endif
    input  logic                    err_clr
);

    localparam int unsigned IW = $clog2(N);
    localparam int unsigned SW = DW + IW;
    localparam logic [IW-1:0] LastIdx = IW'(N - 1);
`ifdef FRAME_SUM_EN
    localparam int unsigned EW = N * DW + 1 + SW;
`else
    localparam int unsigned EW = N * DW + 1;
`endif

    logic [IW-1:0]   idx_q, idx_d;
    logic [N*DW-1:0] bank_q, bank_d;
    logic            sorted_q, sorted_d;
    logic [EW-1:0]   q_q [2];
    logic [EW-1:0]   q_d [2];
    logic [1:0]      cnt_q, cnt_d;
    logic            err_q, err_d;
    logic            ovf_q, ovf_d;
    logic            push, pop, err_set, ovf_set;
    logic [DW-1:0]   prev_word;
    logic [EW-1:0]   new_entry;
    logic [EW-1:0]   head;
`ifdef FRAME_SUM_EN
    logic [SW-1:0]   sum_q, sum_d;
`endif

    // Assembly: one word per valid cycle into slot idx.
    always_comb begin
        idx_d     = idx_q;
        bank_d    = bank_q;
        sorted_d  = sorted_q;
        push      = 1'b0;
        err_set   = 1'b0;
        prev_word = bank_q[(idx_q - 1'b1) * DW +: DW];
`ifdef FRAME_SUM_EN
        sum_d     = sum_q;
`endif
        if (sort_valid) begin
            if (sort_first) begin
                err_set          = (idx_q != '0);
                bank_d[DW-1:0]   = sort_in;
                sorted_d         = 1'b1;
                idx_d            = IW'(1);
`ifdef FRAME_SUM_EN
                sum_d            = SW'(sort_in);
`endif
            end else if (idx_q == '0) begin
                err_set = 1'b1;
            end else begin
                bank_d[idx_q * DW +: DW] = sort_in;
                sorted_d = sorted_q & (sort_in >= prev_word);
`ifdef FRAME_SUM_EN
                sum_d    = sum_q + SW'(sort_in);
`endif
                if (idx_q == LastIdx) begin
                    push  = 1'b1;
                    idx_d = '0;
                end else begin
                    idx_d = idx_q + 1'b1;
                end
            end
        end
    end

`ifdef FRAME_SUM_EN
    assign new_entry = {sum_d, sorted_d, bank_d};
`else
    assign new_entry = {sorted_d, bank_d};
`endif

    assign frame_valid = (cnt_q != 2'd0);
    assign pop         = frame_valid & frame_ready;

    // Two-entry queue with entry 0 always the head.
    always_comb begin
        q_d[0]  = q_q[0];
        q_d[1]  = q_q[1];
        cnt_d   = cnt_q;
        ovf_set = 1'b0;
        case (cnt_q)
            2'd0: begin
                if (push) begin
                    q_d[0] = new_entry;
                    cnt_d  = 2'd1;
                end
            end
            2'd1: begin
                if (push && pop) begin
                    q_d[0] = new_entry;
                end else if (push) begin
                    q_d[1] = new_entry;
                    cnt_d  = 2'd2;
                end else if (pop) begin
                    cnt_d  = 2'd0;
                end
            end
            2'd2: begin
                if (pop) begin
                    q_d[0] = q_q[1];
                    if (push) begin
                        q_d[1] = new_entry;
                    end else begin
                        cnt_d  = 2'd1;
                    end
                end else if (push) begin
                    ovf_set = 1'b1;
                end
            end
            default: cnt_d = 2'd0;
        endcase
    end

    // Set wins over a simultaneous clear.
    assign err_d = (err_q & ~err_clr) | err_set;
    assign ovf_d = (ovf_q & ~err_clr) | ovf_set;

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            bank_q   <= '0;
            sorted_q <= 1'b0;
            q_q[0]   <= '0;
            q_q[1]   <= '0;
            cnt_q    <= 2'd0;
            err_q    <= 1'b0;
            ovf_q    <= 1'b0;
`ifdef FRAME_SUM_EN
            sum_q    <= '0;
`endif
        end else begin
            idx_q    <= idx_d;
            bank_q   <= bank_d;
            sorted_q <= sorted_d;
            q_q[0]   <= q_d[0];
            q_q[1]   <= q_d[1];
            cnt_q    <= cnt_d;
            err_q    <= err_d;
            ovf_q    <= ovf_d;
`ifdef FRAME_SUM_EN
            sum_q    <= sum_d;
`endif
        end
    end

    assign head         = frame_valid ? q_q[0] : '0;
    assign frame_data   = head[N*DW-1:0];
    assign frame_sorted = head[N*DW];
    assign frame_err    = err_q;
    assign overflow     = ovf_q;
`ifdef FRAME_SUM_EN
    assign frame_sum    = head[EW-1 -: SW];
`endif

endmodule

// File: tb/tb_sorted_frame_collector.sv
// Directed bench for sorted_frame_collector (DW=8, N=4): vector table plus corner sequences.
module tb_sorted_frame_collector;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  sort_in;
    logic        sort_valid;
    logic        sort_first;
    logic [31:0] frame_data;
    logic        frame_sorted;
    logic        frame_valid;
    logic        frame_ready;
    logic        frame_err;
    logic        overflow;
    logic        err_clr;
`ifdef FRAME_SUM_EN
    logic [9:0]  frame_sum;
`endif

    int total = 0;
    int bad   = 0;

    sorted_frame_collector #(
        .DW(8),
        .N (4)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .sort_in     (sort_in),
        .sort_valid  (sort_valid),
        .sort_first  (sort_first),
        .frame_data  (frame_data),
        .frame_sorted(frame_sorted),
        .frame_valid (frame_valid),
        .frame_ready (frame_ready),
        .frame_err   (frame_err),
        .overflow    (overflow),
`ifdef FRAME_SUM_EN
        .frame_sum   (frame_sum),
`endif
        .err_clr     (err_clr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [7:0]  w0, w1, w2, w3;
        logic [31:0] data;
        logic        sorted;
    } vec_t;

    vec_t vecs [5];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [7:0] w, input logic f);
        sort_in    = w;
        sort_valid = 1'b1;
        sort_first = f;
        @(posedge clk);
        #1;
        sort_valid = 1'b0;
        sort_first = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic frame4(input logic [7:0] a, b, c, d);
        drive(a, 1'b1);
        drive(b, 1'b0);
        drive(c, 1'b0);
        drive(d, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        vecs[0] = '{8'h03, 8'h05, 8'h09, 8'h0C, 32'h0C090503, 1'b1};
        vecs[1] = '{8'h07, 8'h02, 8'h08, 8'h09, 32'h09080207, 1'b0};
        vecs[2] = '{8'h04, 8'h04, 8'h04, 8'h04, 32'h04040404, 1'b1};
        vecs[3] = '{8'h10, 8'h20, 8'h20, 8'h1F, 32'h1F202010, 1'b0};
        vecs[4] = '{8'h00, 8'h00, 8'hFF, 8'hFF, 32'hFFFF0000, 1'b1};

        rst = 1'b1; sort_in = '0; sort_valid = 1'b0; sort_first = 1'b0;
        frame_ready = 1'b1; err_clr = 1'b0;
        idle(2);
        check("reset_valid", 32'(frame_valid), 32'd0);
        check("reset_data", frame_data, 32'd0);
        check("reset_err", 32'(frame_err), 32'd0);
        check("reset_ovf", 32'(overflow), 32'd0);
        rst = 1'b0;
        idle(1);

        // Table-driven frames, consumer always ready.
        for (int i = 0; i < 5; i++) begin
            frame4(vecs[i].w0, vecs[i].w1, vecs[i].w2, vecs[i].w3);
            check($sformatf("vec%0d_valid", i), 32'(frame_valid), 32'd1);
            check($sformatf("vec%0d_data", i), frame_data, vecs[i].data);
            check($sformatf("vec%0d_sorted", i), 32'(frame_sorted), 32'(vecs[i].sorted));
            check($sformatf("vec%0d_err", i), 32'(frame_err), 32'd0);
            idle(1);
            check($sformatf("vec%0d_gone", i), 32'(frame_valid), 32'd0);
            check($sformatf("vec%0d_zero", i), frame_data, 32'd0);
        end

        // Gaps inside a frame are legal.
        drive(8'h01, 1'b1);
        idle(1);
        drive(8'h02, 1'b0);
        idle(2);
        drive(8'h03, 1'b0);
        drive(8'h04, 1'b0);
        check("gap_data", frame_data, 32'h04030201);
        check("gap_sorted", 32'(frame_sorted), 32'd1);
        idle(1);

        // Three frames into a stalled queue: third is dropped.
        frame_ready = 1'b0;
        frame4(8'h11, 8'h12, 8'h13, 8'h14);
        frame4(8'h21, 8'h22, 8'h23, 8'h24);
        frame4(8'h31, 8'h32, 8'h33, 8'h34);
        check("ovf_set", 32'(overflow), 32'd1);
        check("ovf_head", frame_data, 32'h14131211);
        idle(2);
        check("ovf_stable", frame_data, 32'h14131211);
        frame_ready = 1'b1;
        idle(1);
        check("ovf_second", frame_data, 32'h24232221);
        idle(1);
        check("ovf_empty", 32'(frame_valid), 32'd0);
        check("ovf_sticky", 32'(overflow), 32'd1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("ovf_clr", 32'(overflow), 32'd0);

        // Full queue with a pop on the same edge the next frame completes.
        frame_ready = 1'b0;
        frame4(8'h41, 8'h42, 8'h43, 8'h44);
        frame4(8'h51, 8'h52, 8'h53, 8'h54);
        drive(8'h61, 1'b1);
        drive(8'h62, 1'b0);
        drive(8'h63, 1'b0);
        frame_ready = 1'b1;
        drive(8'h64, 1'b0);
        check("pp_head", frame_data, 32'h54535251);
        check("pp_noovf", 32'(overflow), 32'd0);
        idle(1);
        check("pp_third", frame_data, 32'h64636261);
        idle(1);
        check("pp_empty", 32'(frame_valid), 32'd0);

        // Restart mid-frame.
        drive(8'h01, 1'b1);
        drive(8'h02, 1'b0);
        frame4(8'h10, 8'h11, 8'h12, 8'h13);
        check("ferr_set", 32'(frame_err), 32'd1);
        check("ferr_data", frame_data, 32'h13121110);
        check("ferr_valid", 32'(frame_valid), 32'd1);
        idle(1);
        check("ferr_single", 32'(frame_valid), 32'd0);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("ferr_clr", 32'(frame_err), 32'd0);

        // Stray non-first word at idx 0, then set wins over clear.
        drive(8'h55, 1'b0);
        check("stray_err", 32'(frame_err), 32'd1);
        check("stray_novalid", 32'(frame_valid), 32'd0);
        err_clr = 1'b1;
        drive(8'h66, 1'b0);
        err_clr = 1'b0;
        check("setwins_err", 32'(frame_err), 32'd1);
        err_clr = 1'b1;
        idle(1);
        err_clr = 1'b0;
        check("setwins_clr", 32'(frame_err), 32'd0);

        // Reset discards queued and partial frames.
        frame_ready = 1'b0;
        frame4(8'h05, 8'h06, 8'h07, 8'h08);
        drive(8'h01, 1'b1);
        drive(8'h02, 1'b0);
        rst = 1'b1;
        idle(1);
        rst = 1'b0;
        check("rst_valid", 32'(frame_valid), 32'd0);
        check("rst_data", frame_data, 32'd0);
        check("rst_sorted", 32'(frame_sorted), 32'd0);
        idle(1);
        check("rst_still_empty", 32'(frame_valid), 32'd0);
        frame_ready = 1'b1;
        frame4(8'h01, 8'h02, 8'h03, 8'h04);
        check("rst_after_data", frame_data, 32'h04030201);
        check("rst_after_err", 32'(frame_err), 32'd0);
        check("rst_after_ovf", 32'(overflow), 32'd0);
        idle(1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
